// File: rtl/axi_regbus_pkg.sv
// rtl/axi_regbus_pkg.sv - shared state, response and burst encodings for the AXI register-bus bridge
package axi_regbus_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WDATA = 3'd1,
    WACC  = 3'd2,
    BRESP = 3'd3,
    RACC  = 3'd4,
    RDATA = 3'd5
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  // Only FIXED and INCR with beats no wider than the data bus reach the register bus.
  function automatic logic burst_supported(input logic [2:0] size, input logic [1:0] burst,
                                           input logic [2:0] max_size);
    return ((burst == BURST_FIXED) || (burst == BURST_INCR)) && (size <= max_size);
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// rtl/axi_burst_addr_gen.sv - next beat address and support check for one AXI burst
module axi_burst_addr_gen
  import axi_regbus_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int STRB_WIDTH = 4
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [2:0]            size_i,
  input  logic [1:0]            burst_i,
  output logic [ADDR_WIDTH-1:0] next_addr_o,
  output logic                  supported_o
);

  localparam logic [2:0] MAX_SIZE = 3'($clog2(STRB_WIDTH));

  always_comb begin
    supported_o = burst_supported(size_i, burst_i, MAX_SIZE);
    next_addr_o = addr_i;
    if (supported_o && (burst_i == BURST_INCR)) begin
      next_addr_o = addr_i + (ADDR_WIDTH'(1) << size_i);
    end
  end

endmodule

// File: rtl/axi_regbus_bridge.sv
// rtl/axi_regbus_bridge.sv - AXI4 slave replaying bursts as single-word register-bus accesses
// Define AXI_REGBUS_TIMEOUT_EN to abort accesses that see no reg_ack within TIMEOUT_CYCLES.
module axi_regbus_bridge
  import axi_regbus_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int STRB_WIDTH     = DATA_WIDTH / 8,
  parameter int ID_WIDTH       = 8,
  parameter int REG_ADDR_WIDTH = 16,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ID_WIDTH-1:0]       s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]     s_axi_awaddr,
  input  logic [7:0]                s_axi_awlen,
  input  logic [2:0]                s_axi_awsize,
  input  logic [1:0]                s_axi_awburst,
  input  logic                      s_axi_awvalid,
  output logic                      s_axi_awready,
  input  logic [ID_WIDTH-1:0]       s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]     s_axi_araddr,
  input  logic [7:0]                s_axi_arlen,
  input  logic [2:0]                s_axi_arsize,
  input  logic [1:0]                s_axi_arburst,
  input  logic                      s_axi_arvalid,
  output logic                      s_axi_arready,
  input  logic [DATA_WIDTH-1:0]     s_axi_wdata,
  input  logic [STRB_WIDTH-1:0]     s_axi_wstrb,
  input  logic                      s_axi_wlast,
  input  logic                      s_axi_wvalid,
  output logic                      s_axi_wready,
  output logic [ID_WIDTH-1:0]       s_axi_bid,
  output logic [1:0]                s_axi_bresp,
  output logic                      s_axi_bvalid,
  input  logic                      s_axi_bready,
  output logic [ID_WIDTH-1:0]       s_axi_rid,
  output logic [DATA_WIDTH-1:0]     s_axi_rdata,
  output logic [1:0]                s_axi_rresp,
  output logic                      s_axi_rlast,
  output logic                      s_axi_rvalid,
  input  logic                      s_axi_rready,
  output logic                      reg_req,
  output logic                      reg_we,
  output logic [REG_ADDR_WIDTH-1:0] reg_addr,
  output logic [DATA_WIDTH-1:0]     reg_wdata,
  output logic [STRB_WIDTH-1:0]     reg_wstrb,
  input  logic                      reg_ack,
  input  logic [DATA_WIDTH-1:0]     reg_rdata,
  input  logic                      reg_err
);

  localparam logic [2:0] MAX_SIZE = 3'($clog2(STRB_WIDTH));
  localparam logic [REG_ADDR_WIDTH-1:0] WORD_MASK = ~REG_ADDR_WIDTH'(STRB_WIDTH - 1);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  state_e                    state_q;
  logic                      prio_wr_q;
  logic                      awready_q, arready_q, wready_q;
  logic                      bvalid_q, rvalid_q, rlast_q;
  logic [1:0]                bresp_q, rresp_q;
  logic [DATA_WIDTH-1:0]     rdata_q;
  logic                      reg_req_q, reg_we_q;
  logic [REG_ADDR_WIDTH-1:0] reg_addr_q;
  logic [DATA_WIDTH-1:0]     reg_wdata_q;
  logic [STRB_WIDTH-1:0]     reg_wstrb_q;
  logic [ID_WIDTH-1:0]       id_q;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [7:0]                len_q, beat_q;
  logic [2:0]                size_q;
  logic [1:0]                burst_q;
  logic                      err_q;
  logic                      supported;
  logic                      last_beat;
  logic                      acc_done, acc_err;
  logic [DATA_WIDTH-1:0]     acc_rdata;

  function automatic logic [REG_ADDR_WIDTH-1:0] word_addr(input logic [ADDR_WIDTH-1:0] a);
    return a[REG_ADDR_WIDTH-1:0] & WORD_MASK;
  endfunction

  axi_burst_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .STRB_WIDTH(STRB_WIDTH)
  ) u_addr_gen (
    .addr_i     (addr_q),
    .size_i     (size_q),
    .burst_i    (burst_q),
    .next_addr_o(addr_d),
    .supported_o(supported)
  );

  assign last_beat = (beat_q == len_q);

`ifdef AXI_REGBUS_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q;
  logic             tmo_hit;

  assign tmo_hit = reg_req_q && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_q <= '0;
    end else if (!reg_req_q || acc_done) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_q + 1'b1;
    end
  end

  // A real ack in the expiry cycle still wins over the internal abort.
  always_comb begin
    acc_done  = reg_req_q && (reg_ack || tmo_hit);
    acc_err   = reg_ack ? reg_err : 1'b1;
    acc_rdata = reg_ack ? reg_rdata : '0;
  end
`else
  always_comb begin
    acc_done  = reg_req_q && reg_ack;
    acc_err   = reg_err;
    acc_rdata = reg_rdata;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      prio_wr_q   <= 1'b1;
      awready_q   <= 1'b0;
      arready_q   <= 1'b0;
      wready_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      bresp_q     <= RESP_OKAY;
      rvalid_q    <= 1'b0;
      rlast_q     <= 1'b0;
      rresp_q     <= RESP_OKAY;
      rdata_q     <= '0;
      reg_req_q   <= 1'b0;
      reg_we_q    <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_wstrb_q <= '0;
      id_q        <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      size_q      <= '0;
      burst_q     <= '0;
      beat_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (awready_q) begin
            awready_q <= 1'b0;
            if (s_axi_awvalid) begin
              id_q     <= s_axi_awid;
              addr_q   <= s_axi_awaddr;
              len_q    <= s_axi_awlen;
              size_q   <= s_axi_awsize;
              burst_q  <= s_axi_awburst;
              beat_q   <= '0;
              err_q    <= 1'b0;
              wready_q <= 1'b1;
              state_q  <= WDATA;
            end
          end else if (arready_q) begin
            arready_q <= 1'b0;
            if (s_axi_arvalid) begin
              id_q    <= s_axi_arid;
              addr_q  <= s_axi_araddr;
              len_q   <= s_axi_arlen;
              size_q  <= s_axi_arsize;
              burst_q <= s_axi_arburst;
              beat_q  <= '0;
              if (burst_supported(s_axi_arsize, s_axi_arburst, MAX_SIZE)) begin
                reg_req_q  <= 1'b1;
                reg_we_q   <= 1'b0;
                reg_addr_q <= word_addr(s_axi_araddr);
                state_q    <= RACC;
              end else begin
                rvalid_q <= 1'b1;
                rdata_q  <= '0;
                rresp_q  <= RESP_SLVERR;
                rlast_q  <= (s_axi_arlen == 8'd0);
                state_q  <= RDATA;
              end
            end
          end else if (s_axi_awvalid && (!s_axi_arvalid || prio_wr_q)) begin
            awready_q <= 1'b1;
            prio_wr_q <= 1'b0;
          end else if (s_axi_arvalid) begin
            arready_q <= 1'b1;
            prio_wr_q <= 1'b1;
          end
        end

        WDATA: begin
          if (s_axi_wvalid) begin
            if (s_axi_wlast != last_beat) err_q <= 1'b1;
            if (supported) begin
              reg_wdata_q <= s_axi_wdata;
              reg_wstrb_q <= s_axi_wstrb;
              reg_addr_q  <= word_addr(addr_q);
              wready_q    <= 1'b0;
              reg_req_q   <= 1'b1;
              reg_we_q    <= 1'b1;
              state_q     <= WACC;
            end else begin
              // Unsupported bursts drain every W beat without touching the register bus.
              err_q <= 1'b1;
              if (last_beat) begin
                wready_q <= 1'b0;
                bvalid_q <= 1'b1;
                bresp_q  <= RESP_SLVERR;
                state_q  <= BRESP;
              end else begin
                beat_q <= beat_q + 8'd1;
              end
            end
          end
        end

        WACC: begin
          if (acc_done) begin
            reg_req_q <= 1'b0;
            reg_we_q  <= 1'b0;
            err_q     <= err_q | acc_err;
            if (last_beat) begin
              bvalid_q <= 1'b1;
              bresp_q  <= (err_q || acc_err) ? RESP_SLVERR : RESP_OKAY;
              state_q  <= BRESP;
            end else begin
              beat_q   <= beat_q + 8'd1;
              addr_q   <= addr_d;
              wready_q <= 1'b1;
              state_q  <= WDATA;
            end
          end
        end

        BRESP: begin
          if (s_axi_bready) begin
            bvalid_q <= 1'b0;
            err_q    <= 1'b0;
            state_q  <= IDLE;
          end
        end

        RACC: begin
          if (acc_done) begin
            reg_req_q <= 1'b0;
            rdata_q   <= acc_rdata;
            rresp_q   <= acc_err ? RESP_SLVERR : RESP_OKAY;
            rlast_q   <= last_beat;
            rvalid_q  <= 1'b1;
            state_q   <= RDATA;
          end
        end

        RDATA: begin
          if (s_axi_rready) begin
            if (rlast_q) begin
              rvalid_q <= 1'b0;
              rlast_q  <= 1'b0;
              state_q  <= IDLE;
            end else begin
              beat_q <= beat_q + 8'd1;
              addr_q <= addr_d;
              if (supported) begin
                rvalid_q   <= 1'b0;
                reg_req_q  <= 1'b1;
                reg_addr_q <= word_addr(addr_d);
                state_q    <= RACC;
              end else begin
                rdata_q <= '0;
                rresp_q <= RESP_SLVERR;
                rlast_q <= (beat_q + 8'd1 == len_q);
              end
            end
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_arready = arready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bid     = id_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_rid     = id_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rlast   = rlast_q;
  assign s_axi_rvalid  = rvalid_q;
  assign reg_req       = reg_req_q;
  assign reg_we        = reg_we_q;
  assign reg_addr      = reg_addr_q;
  assign reg_wdata     = reg_wdata_q;
  assign reg_wstrb     = reg_wstrb_q;

endmodule

// File: tb/tb_axi_regbus_bridge.sv
// tb/tb_axi_regbus_bridge.sv - directed scoreboard bench for axi_regbus_bridge
module tb_axi_regbus_bridge;
  import axi_regbus_pkg::*;

  localparam int BOUND = 200;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  s_axi_awid = '0, s_axi_arid = '0;
  logic [31:0] s_axi_awaddr = '0, s_axi_araddr = '0;
  logic [7:0]  s_axi_awlen = '0, s_axi_arlen = '0;
  logic [2:0]  s_axi_awsize = '0, s_axi_arsize = '0;
  logic [1:0]  s_axi_awburst = '0, s_axi_arburst = '0;
  logic        s_axi_awvalid = 1'b0, s_axi_arvalid = 1'b0;
  logic        s_axi_awready, s_axi_arready;
  logic [31:0] s_axi_wdata = '0;
  logic [3:0]  s_axi_wstrb = '0;
  logic        s_axi_wlast = 1'b0, s_axi_wvalid = 1'b0;
  logic        s_axi_wready;
  logic [7:0]  s_axi_bid;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready = 1'b1;
  logic [7:0]  s_axi_rid;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rlast, s_axi_rvalid;
  logic        s_axi_rready = 1'b1;
  logic        reg_req, reg_we;
  logic [15:0] reg_addr;
  logic [31:0] reg_wdata;
  logic [3:0]  reg_wstrb;
  logic        reg_ack = 1'b0;
  logic [31:0] reg_rdata = '0;
  logic        reg_err = 1'b0;

  always #5 clk = ~clk;

  axi_regbus_bridge #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .reg_req(reg_req), .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_wstrb(reg_wstrb), .reg_ack(reg_ack), .reg_rdata(reg_rdata), .reg_err(reg_err)
  );

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic        err;
  } reg_exp_t;

  typedef struct packed {
    logic [7:0] id;
    logic [1:0] resp;
  } b_exp_t;

  typedef struct packed {
    logic [7:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_exp_t;

  reg_exp_t reg_q[$];
  b_exp_t   b_q[$];
  r_exp_t   r_q[$];

  int n_asserts = 0;
  int n_fails   = 0;
  int ack_delay = 2;
  bit ack_en    = 1'b1;
  int req_cnt   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void push_reg(input logic we, input logic [15:0] addr, input logic [31:0] wdata,
                                   input logic [3:0] wstrb, input logic [31:0] rdata, input logic err);
    reg_exp_t e;
    e.we = we; e.addr = addr; e.wdata = wdata; e.wstrb = wstrb; e.rdata = rdata; e.err = err;
    reg_q.push_back(e);
  endfunction

  function automatic void push_b(input logic [7:0] id, input logic [1:0] resp);
    b_exp_t e;
    e.id = id; e.resp = resp;
    b_q.push_back(e);
  endfunction

  function automatic void push_r(input logic [7:0] id, input logic [31:0] data, input logic [1:0] resp,
                                 input logic last);
    r_exp_t e;
    e.id = id; e.data = data; e.resp = resp; e.last = last;
    r_q.push_back(e);
  endfunction

  // Register-bus responder: acks after ack_delay cycles of reg_req and checks each access in order.
  always @(negedge clk) begin : responder
    reg_exp_t e;
    reg_ack = 1'b0;
    if (rst || !reg_req) begin
      req_cnt = 0;
    end else if (ack_en) begin
      req_cnt++;
      if (req_cnt >= ack_delay) begin
        req_cnt = 0;
        check("reg_pending", 32'(reg_q.size() != 0), 32'd1);
        if (reg_q.size() != 0) begin
          e = reg_q.pop_front();
          check("reg_we", reg_we, e.we);
          check("reg_addr", reg_addr, e.addr);
          if (e.we) begin
            check("reg_wdata", reg_wdata, e.wdata);
            check("reg_wstrb", reg_wstrb, e.wstrb);
          end
          reg_rdata = e.rdata;
          reg_err   = e.err;
          reg_ack   = 1'b1;
        end
      end
    end
  end

  task automatic aw_send(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len;
    s_axi_awsize = size; s_axi_awburst = burst; s_axi_awvalid = 1'b1;
    while (!s_axi_awready && n < BOUND) begin @(negedge clk); n++; end
    check("aw_handshake", s_axi_awready, 1'b1);
    @(negedge clk);
    s_axi_awvalid = 1'b0;
  endtask

  task automatic ar_send(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len;
    s_axi_arsize = size; s_axi_arburst = burst; s_axi_arvalid = 1'b1;
    while (!s_axi_arready && n < BOUND) begin @(negedge clk); n++; end
    check("ar_handshake", s_axi_arready, 1'b1);
    @(negedge clk);
    s_axi_arvalid = 1'b0;
  endtask

  task automatic w_beat(input logic [31:0] data, input logic [3:0] strb, input logic last);
    int n = 0;
    s_axi_wdata = data; s_axi_wstrb = strb; s_axi_wlast = last; s_axi_wvalid = 1'b1;
    while (!s_axi_wready && n < BOUND) begin @(negedge clk); n++; end
    check("w_handshake", s_axi_wready, 1'b1);
    @(negedge clk);
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
  endtask

  task automatic wait_b();
    int n = 0;
    b_exp_t e;
    while (!s_axi_bvalid && n < BOUND) begin @(negedge clk); n++; end
    check("b_valid", s_axi_bvalid, 1'b1);
    e = b_q.pop_front();
    check("bid", s_axi_bid, e.id);
    check("bresp", s_axi_bresp, e.resp);
    @(negedge clk);
  endtask

  task automatic collect_r(input int beats);
    r_exp_t e;
    for (int i = 0; i < beats; i++) begin
      int n = 0;
      while (!s_axi_rvalid && n < BOUND) begin @(negedge clk); n++; end
      check("r_valid", s_axi_rvalid, 1'b1);
      e = r_q.pop_front();
      check("rid", s_axi_rid, e.id);
      check("rdata", s_axi_rdata, e.data);
      check("rresp", s_axi_rresp, e.resp);
      check("rlast", s_axi_rlast, e.last);
      @(negedge clk);
    end
  endtask

  task automatic wait_any_ready();
    int n = 0;
    while (!s_axi_awready && !s_axi_arready && n < BOUND) begin @(negedge clk); n++; end
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("rst_ready", {s_axi_awready, s_axi_arready, s_axi_wready}, 3'b000);
    check("rst_valid", {s_axi_bvalid, s_axi_rvalid, reg_req, reg_we}, 4'b0000);
    check("rst_rdata", s_axi_rdata, 32'h0);
    check("rst_ids", {s_axi_bid, s_axi_rid, reg_addr}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // INCR write, four beats
    for (int i = 0; i < 4; i++) push_reg(1'b1, 16'h0100 + 16'(4 * i), 32'h1000 + 32'(i), 4'hF, 32'h0, 1'b0);
    push_b(8'h5A, RESP_OKAY);
    aw_send(8'h5A, 32'h0000_0100, 8'd3, 3'd2, BURST_INCR);
    for (int i = 0; i < 4; i++) w_beat(32'h1000 + 32'(i), 4'hF, i == 3);
    wait_b();

    // FIXED read, three beats from one register
    push_reg(1'b0, 16'h0040, 32'h0, 4'h0, 32'hA, 1'b0);
    push_reg(1'b0, 16'h0040, 32'h0, 4'h0, 32'hB, 1'b0);
    push_reg(1'b0, 16'h0040, 32'h0, 4'h0, 32'hC, 1'b0);
    push_r(8'h33, 32'hA, RESP_OKAY, 1'b0);
    push_r(8'h33, 32'hB, RESP_OKAY, 1'b0);
    push_r(8'h33, 32'hC, RESP_OKAY, 1'b1);
    ar_send(8'h33, 32'h0000_0040, 8'd2, 3'd2, BURST_FIXED);
    collect_r(3);

    // INCR read with an error on the middle beat
    push_reg(1'b0, 16'h0080, 32'h0, 4'h0, 32'h1, 1'b0);
    push_reg(1'b0, 16'h0084, 32'h0, 4'h0, 32'h2, 1'b1);
    push_reg(1'b0, 16'h0088, 32'h0, 4'h0, 32'h3, 1'b0);
    push_r(8'h34, 32'h1, RESP_OKAY, 1'b0);
    push_r(8'h34, 32'h2, RESP_SLVERR, 1'b0);
    push_r(8'h34, 32'h3, RESP_OKAY, 1'b1);
    ar_send(8'h34, 32'h0000_0080, 8'd2, 3'd2, BURST_INCR);
    collect_r(3);

    // Simultaneous AW/AR twice: write first, then read; read beat held with rready low
    push_reg(1'b1, 16'h0010, 32'hDEAD_0001, 4'h3, 32'h0, 1'b0);
    push_reg(1'b0, 16'h0020, 32'h0, 4'h0, 32'hCAFE, 1'b0);
    push_reg(1'b1, 16'h0014, 32'h0000_0077, 4'hC, 32'h0, 1'b0);
    push_b(8'h11, RESP_OKAY);
    push_r(8'h22, 32'hCAFE, RESP_OKAY, 1'b1);
    push_b(8'h12, RESP_OKAY);
    s_axi_rready = 1'b0;
    s_axi_arid = 8'h22; s_axi_araddr = 32'h20; s_axi_arlen = 8'd0;
    s_axi_arsize = 3'd2; s_axi_arburst = BURST_INCR; s_axi_arvalid = 1'b1;
    s_axi_awid = 8'h11; s_axi_awaddr = 32'h10; s_axi_awlen = 8'd0;
    s_axi_awsize = 3'd2; s_axi_awburst = BURST_INCR; s_axi_awvalid = 1'b1;
    wait_any_ready();
    check("arb1_awready", s_axi_awready, 1'b1);
    check("arb1_arready", s_axi_arready, 1'b0);
    aw_send(8'h11, 32'h10, 8'd0, 3'd2, BURST_INCR);
    s_axi_awid = 8'h12; s_axi_awaddr = 32'h14; s_axi_awvalid = 1'b1;
    w_beat(32'hDEAD_0001, 4'h3, 1'b1);
    wait_b();
    wait_any_ready();
    check("arb2_arready", s_axi_arready, 1'b1);
    check("arb2_awready", s_axi_awready, 1'b0);
    ar_send(8'h22, 32'h20, 8'd0, 3'd2, BURST_INCR);
    n = 0;
    while (!s_axi_rvalid && n < BOUND) begin @(negedge clk); n++; end
    for (int i = 0; i < 5; i++) begin
      check("hold_rvalid", s_axi_rvalid, 1'b1);
      check("hold_rdata", s_axi_rdata, 32'hCAFE);
      @(negedge clk);
    end
    s_axi_rready = 1'b1;
    collect_r(1);
    aw_send(8'h12, 32'h14, 8'd0, 3'd2, BURST_INCR);
    w_beat(32'h0000_0077, 4'hC, 1'b1);
    wait_b();

    // WRAP read: no register traffic, four error beats
    for (int i = 0; i < 4; i++) push_r(8'h44, 32'h0, RESP_SLVERR, i == 3);
    ar_send(8'h44, 32'h0000_0030, 8'd3, 3'd2, BURST_WRAP);
    collect_r(4);

    // Oversized beat write: both beats drained, SLVERR
    push_b(8'h66, RESP_SLVERR);
    aw_send(8'h66, 32'h0000_0050, 8'd1, 3'd3, BURST_INCR);
    w_beat(32'h1, 4'hF, 1'b0);
    w_beat(32'h2, 4'hF, 1'b1);
    wait_b();

    // Early wlast: accesses still issued per awlen, response flagged
    push_reg(1'b1, 16'h0200, 32'hA0, 4'hF, 32'h0, 1'b0);
    push_reg(1'b1, 16'h0204, 32'hA1, 4'hF, 32'h0, 1'b0);
    push_b(8'h77, RESP_SLVERR);
    aw_send(8'h77, 32'h0000_0200, 8'd1, 3'd2, BURST_INCR);
    w_beat(32'hA0, 4'hF, 1'b1);
    w_beat(32'hA1, 4'hF, 1'b0);
    wait_b();

    // Reset while an access is outstanding
    ack_en = 1'b0;
    aw_send(8'h99, 32'h0000_0300, 8'd1, 3'd2, BURST_INCR);
    w_beat(32'h55, 4'hF, 1'b0);
    check("mid_req_up", reg_req, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ack_en = 1'b1;
    repeat (4) @(negedge clk);
    check("mid_rst_req", reg_req, 1'b0);
    check("mid_rst_outs", {s_axi_wready, s_axi_bvalid, s_axi_rvalid, s_axi_awready}, 4'b0000);

`ifdef AXI_REGBUS_TIMEOUT_EN
    ack_en = 1'b0;
    push_b(8'hAB, RESP_SLVERR);
    aw_send(8'hAB, 32'h0000_0400, 8'd0, 3'd2, BURST_INCR);
    w_beat(32'h99, 4'hF, 1'b1);
    check("tmo_req_up", reg_req, 1'b1);
    n = 0;
    while (reg_req && n < BOUND) begin @(negedge clk); n++; end
    check("tmo_cycles", n, 16);
    wait_b();
    ack_en = 1'b1;
`endif

    check("reg_q_empty", reg_q.size(), 0);
    check("b_q_empty", b_q.size(), 0);
    check("r_q_empty", r_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
